// File: rtl/cache_miss_responder.sv
// cache_miss_responder: services a cache miss over a req/ready memory port (optional write-back, then fill).
// Optional macro CACHE_WB_BUFFER_EN: one-entry write-back buffer, fill first, write drained after the response.
module cache_miss_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_req,
  input  logic [RAM_ADDR_WIDTH-1:0] miss_addr,
  input  logic                      wb_req,
  input  logic [RAM_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      stall,
  output logic                      fill_valid,
  output logic [DATA_WIDTH-1:0]     fill_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [2:0] { S_IDLE, S_WB, S_FILL, S_RESP, S_DRAIN } state_e;

  localparam logic [RAM_ADDR_WIDTH-1:0] WORD_MASK = ~(RAM_ADDR_WIDTH'(3));

  state_e                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0]     fill_data_q, fill_data_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;

  logic                      mem_done;
  logic                      fwd_hit;
  logic                      issue;
  logic                      issue_we;
  logic [RAM_ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0]     issue_wdata;
  logic                      stall_raw;

`ifdef CACHE_WB_BUFFER_EN
  logic buf_valid_q, buf_valid_d;

  // wb_addr_q/wb_data_q double as the buffer entry; a fill hitting it never touches memory.
  assign fwd_hit = buf_valid_q && ((miss_addr_q & WORD_MASK) == (wb_addr_q & WORD_MASK));
`else
  assign fwd_hit = 1'b0;
`endif

  assign mem_done = mem_req_q && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_WB_BUFFER_EN
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_data_q <= fill_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_WB_BUFFER_EN
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_data_d = fill_data_q;
`ifdef CACHE_WB_BUFFER_EN
    buf_valid_d = buf_valid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          miss_addr_d = miss_addr;
          wb_addr_d   = wb_addr;
          wb_data_d   = wb_data;
`ifdef CACHE_WB_BUFFER_EN
          buf_valid_d = wb_req;
          state_d     = S_FILL;
`else
          state_d     = wb_req ? S_WB : S_FILL;
`endif
        end
      end
      S_WB: begin
        if (mem_done) state_d = S_FILL;
      end
      S_FILL: begin
        if (fwd_hit) begin
          fill_data_d = wb_data_q;
          state_d     = S_RESP;
        end else if (mem_done) begin
          fill_data_d = mem_rdata;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
`ifdef CACHE_WB_BUFFER_EN
        state_d = buf_valid_q ? S_DRAIN : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DRAIN: begin
        if (mem_done) begin
`ifdef CACHE_WB_BUFFER_EN
          buf_valid_d = 1'b0;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request is raised the cycle after its state is entered and its fields are frozen until completion.
  always_comb begin
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = miss_addr_q & WORD_MASK;
    issue_wdata = '0;
    case (state_q)
      S_WB, S_DRAIN: begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = wb_addr_q & WORD_MASK;
        issue_wdata = wb_data_q;
      end
      S_FILL:  issue = !fwd_hit;
      default: issue = 1'b0;
    endcase
    mem_req_d   = issue && !mem_done;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (mem_req_d && !mem_req_q) begin
      mem_we_d    = issue_we;
      mem_addr_d  = issue_addr;
      mem_wdata_d = issue_wdata;
    end
  end

  always_comb begin
    fill_valid = (state_q == S_RESP);
    case (state_q)
      S_WB, S_FILL:    stall_raw = 1'b1;
      S_IDLE, S_DRAIN: stall_raw = miss_req;
      default:         stall_raw = 1'b0;
    endcase
    stall = stall_raw && rst_n;
  end

  assign fill_data = fill_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
